// File: rtl/div_recon_16bit.sv
// Reconstructs a dividend from a divider's quotient/remainder pair as
// A = Q*B + R using an 8-step shift-and-add multiply (LSB of B first).
// Flags overflow past 16 bits and invalid remainders (R >= B, incl. B == 0).
module div_recon_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] Q,
    input  logic [7:0]  B,
    input  logic [15:0] R,
    output logic [15:0] A,
    output logic        ovf,
    output logic        rem_err,
    output logic        busy,
    output logic        done
);

    localparam int unsigned QW = 16;
    localparam int unsigned BW = 8;
    localparam int unsigned AW = 24;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [QW-1:0]   r_q;
    logic [BW-1:0]   r_b;
    logic [QW-1:0]   r_r;
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [QW-1:0]   r_a;
    logic            r_ovf;
    logic            r_rem_err;
    logic            r_busy;
    logic            r_done;

    logic            w_accept;
    logic            w_last;
    logic [AW-1:0]   w_pp;
    logic [AW-1:0]   w_acc_sum;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_cnt == CW'(BW - 1));
    assign w_pp      = r_b[r_cnt] ? (AW'(r_q) << r_cnt) : '0;
    assign w_acc_sum = r_acc + w_pp;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start outside IDLE is simply dropped
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start)  w_state_nxt = S_MUL;
            S_MUL:  if (w_last) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status flags registered from the next state so they track the FSM exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    // Operand capture, shift-and-add accumulation and result write-back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_b       <= '0;
            r_r       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_ovf     <= 1'b0;
            r_rem_err <= 1'b0;
        end else if (w_accept) begin
            r_q   <= Q;
            r_b   <= B;
            r_r   <= R;
            r_acc <= AW'(R);
            r_cnt <= '0;
        end else if (r_state == S_MUL) begin
            r_acc <= w_acc_sum;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_a       <= w_acc_sum[QW-1:0];
                r_ovf     <= |w_acc_sum[AW-1:QW];
                r_rem_err <= (r_r >= {8'h00, r_b});
            end
        end
    end

    assign A       = r_a;
    assign ovf     = r_ovf;
    assign rem_err = r_rem_err;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_div_recon_16bit.sv
// Directed-vector bench for div_recon_16bit with hand-computed results.
module tb_div_recon_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] Q;
    logic [7:0]  B;
    logic [15:0] R;
    logic [15:0] A;
    logic        ovf;
    logic        rem_err;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    div_recon_16bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .Q       (Q),
        .B       (B),
        .R       (R),
        .A       (A),
        .ovf     (ovf),
        .rem_err (rem_err),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start high across exactly one edge (the accepting edge)
    task automatic launch(input logic [15:0] q, input logic [7:0] b, input logic [15:0] r, input bit hold);
        Q = q; B = b; R = r; start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
    endtask

    // Count edges after the accepting edge until done is seen (bounded)
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 30) begin
            tick();
            edges++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] q, input logic [7:0] b,
                          input logic [15:0] r, input logic [15:0] ea,
                          input logic eovf, input logic eerr);
        int lat;
        launch(q, b, r, 1'b0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        check({tag, "_lat"}, 32'(lat), 32'd8);
        check({tag, "_A"}, 32'(A), 32'(ea));
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        check({tag, "_rem_err"}, 32'(rem_err), 32'(eerr));
        tick();
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        rst_n = 1'b0; start = 1'b1; Q = 16'hFFFF; B = 8'hFF; R = 16'hFFFF;

        // Reset has priority over start
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_A", 32'(A), 32'd0);
        check("rst_flags", {30'd0, ovf, rem_err}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        run_op("v1", 16'h0119, 8'hE2, 16'h00D6, 16'hF8E8, 1'b0, 1'b0);
        run_op("max", 16'hFFFF, 8'hFF, 16'h00FF, 16'h0000, 1'b1, 1'b1);
        run_op("req", 16'h0001, 8'h10, 16'h0010, 16'h0020, 1'b0, 1'b1);
        run_op("b0", 16'h1234, 8'h00, 16'h0005, 16'h0005, 1'b0, 1'b1);

        // Outputs hold between completions
        tick(); tick();
        check("hold_A", 32'(A), 32'h0005);
        check("hold_err", 32'(rem_err), 32'd1);

        // Back-to-back with start held: second accept on the edge after DONE
        launch(16'h527D, 8'h03, 16'h0001, 1'b1);
        Q = 16'h19CB; B = 8'h02; R = 16'h0001;
        wait_done(lat);
        check("b2b1_lat", 32'(lat), 32'd8);
        check("b2b1_A", 32'(A), 32'hF778);
        check("b2b1_flags", {30'd0, ovf, rem_err}, 32'd0);
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 2) begin
                start = 1'b0;
                check("b2b_reaccept", 32'(busy), 32'd1);
            end
        end while (!done && lat < 30);
        check("b2b_period", 32'(lat), 32'd10);
        check("b2b2_A", 32'(A), 32'h3397);
        tick(); tick();
        check("b2b_stop", 32'(busy), 32'd0);

        // start during MUL is ignored and not queued
        launch(16'h0119, 8'hE2, 16'h00D6, 1'b0);
        tick(); tick(); tick();
        Q = 16'h0003; B = 8'h05; R = 16'h0001; start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            if (done) pulses++;
            tick();
        end
        check("ign_pulses", 32'(pulses), 32'd1);
        check("ign_A", 32'(A), 32'hF8E8);
        check("ign_idle", 32'(busy), 32'd0);

        // Reset during MUL aborts and zeroes outputs
        launch(16'hFFFF, 8'hFF, 16'h00FF, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_A", 32'(A), 32'd0);
        check("abort_flags", {30'd0, ovf, rem_err}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) pulses++;
            tick();
        end
        check("abort_nodone", 32'(pulses), 32'd0);
        run_op("post", 16'h527D, 8'h03, 16'h0001, 16'hF778, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_recon_16bit.md
DIV_RECON_16BIT -- requirements
Module: div_recon_16bit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-003 Port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising clk edge.
REQ-004 Port start, input, 1 bit: request to begin a reconstruction; accepted only in IDLE.
REQ-005 Port Q, input, 16 bits: quotient operand, unsigned, in the divider's result format.
REQ-006 Port B, input, 8 bits: divisor operand, unsigned.
REQ-007 Port R, input, 16 bits: remainder operand, unsigned, in the divider's odd format.
REQ-008 Port A, output, 16 bits: reconstructed dividend, low 16 bits of Q*B+R.
REQ-009 Port ovf, output, 1 bit: set when Q*B+R exceeds 16'hFFFF.
REQ-010 Port rem_err, output, 1 bit: set when R >= B, meaning an invalid divider output pair; set when B = 0.
REQ-011 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse, high only in state DONE.

Function
REQ-013 States SHALL be IDLE, MUL and DONE only.
REQ-014 On an accepting edge (IDLE and start=1), the block SHALL:
- latch Q, B and R;
- load the 24-bit accumulator with R zero-extended;
- clear the 3-bit bit counter;
- move to MUL.
REQ-015 On each MUL edge, the accumulator SHALL add (Q_latched << cnt) if B_latched[cnt]=1, and cnt SHALL increment; B is processed LSB first.
REQ-016 The MUL edge that processes cnt=7 SHALL be the 8th MUL edge; on it the block SHALL:
- write A = acc_final[15:0];
- write ovf = |acc_final[23:16];
- write rem_err = (R_latched >= {8'h00,B_latched});
- move to DONE.
REQ-017 On the DONE edge, the block SHALL return to IDLE; done is high for exactly one cycle.
REQ-018 Latency: done SHALL be high in the cycle following the 9th edge, counting the accepting edge as edge 1.
REQ-019 The accumulator SHALL be 24 bits; the maximum value 16'hFFFF*8'hFF+16'hFFFF = 24'hFFFF00 SHALL NOT wrap.
REQ-020 start in MUL or DONE SHALL be ignored and SHALL NOT be queued.
REQ-021 start held high SHALL be accepted again on the first IDLE edge after DONE (back-to-back period of 10 cycles).
REQ-022 A, ovf and rem_err SHALL hold their values from the last completion until the next completion; operand inputs SHALL be don't-care outside the accepting edge.
REQ-023 B=0: the product term SHALL be 0, A=R[15:0], ovf=0, rem_err=1, with full normal latency.

Reset
REQ-024 When rst_n=0 at an edge, the block SHALL enter IDLE and clear A, ovf, rem_err, done, the accumulator, cnt and the operand registers; busy SHALL be 0 after that edge.
REQ-025 Reset in MUL or DONE SHALL abort the operation: no done pulse, and outputs zeroed.
REQ-026 Reset SHALL take priority over start on the same edge.

Verification
REQ-027 Q=16'h0119, B=8'hE2, R=16'h00D6, start pulse -> done one cycle after 9 edges; A=16'hF8E8, ovf=0, rem_err=0.
REQ-028 Q=16'h527D, B=8'h03, R=16'h0001 -> A=16'hF778, ovf=0, rem_err=0; then Q=16'h19CB, B=8'h02, R=16'h0001 back-to-back with start held -> A=16'h3397, second done 10 cycles after the first.
REQ-029 Q=16'hFFFF, B=8'hFF, R=16'h00FF -> A=16'h0000, ovf=1, rem_err=1.
REQ-030 Q=16'h0001, B=8'h10, R=16'h0010 -> A=16'h0020, rem_err=1; B=8'h00, Q=16'h1234, R=16'h0005 -> A=16'h0005, rem_err=1, ovf=0.
REQ-031 start at the 4th MUL edge with different operands -> ignored; the result matches the first operands, with exactly one done pulse.
REQ-032 rst_n=0 for one edge during MUL -> busy=0 and A/ovf/rem_err=0 next cycle, no done; a fresh start then completes normally.
